wb_reg_bank: RTL and testbench



---
 rtl/wb_reg_bank_pkg.sv | 31 +++
 rtl/wb_reg_bank_if.sv | 140 ++++++++++++++
 rtl/wb_reg_bank.sv | 128 ++++++++++++
 tb/tb_wb_reg_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_reg_bank_pkg.sv
// rtl/wb_reg_bank_pkg.sv - shared widths, word type and helpers for wb_reg_bank
package wb_reg_bank_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef logic [DATA_W-1:0] word_t;

    // Byte k of the result comes from new_w when sel[k] is set, else from old_w.
    function automatic word_t byte_merge(input word_t old_w, input word_t new_w,
                                         input logic [SEL_W-1:0] sel);
        word_t res;
        res = old_w;
        for (int k = 0; k < SEL_W; k++) begin
            if (sel[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_reg_bank_if.sv
// rtl/wb_reg_bank_if.sv - Wishbone handshake: request tracking, optional write/read stages, response muxing
module wb_reg_bank_if
    import wb_reg_bank_pkg::*;
#(
    parameter int ADDR_W  = 2,
    parameter int WR_PIPE = 1,
    parameter int RD_PIPE = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [SEL_W-1:0]  wb_sel_i,
    input  logic              wb_we_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_stall_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [ADDR_W-1:0] rd_adr_o,
    input  logic              rd_map_i,
    input  logic [DATA_W-1:0] rd_dat_i,
    output logic              rd_ack_o,
    output logic [ADDR_W-1:0] rd_ack_adr_o,
    output logic              wr_com_o,
    output logic [ADDR_W-1:0] wr_adr_o,
    output logic [DATA_W-1:0] wr_dat_o,
    output logic [SEL_W-1:0]  wr_sel_o,
    input  logic              wr_map_i
);

    logic        en;
    logic        rd_req;
    logic        wr_req;
    logic        rip_q;
    logic        rip_d;
    logic        wip_q;
    logic        wip_d;
    logic        rd_ack;
    logic        rd_err;
    logic        wr_ack;
    logic        wr_err;
    word_t       rd_dat;

    assign en       = wb_cyc_i & wb_stb_i;
    assign rd_req   = en & ~wb_we_i & ~rip_q;
    assign wr_req   = en & wb_we_i & ~wip_q;
    assign rd_adr_o = wb_adr_i;

    if (WR_PIPE != 0) begin : g_wr_pipe
        logic              wr_v_q;
        logic [ADDR_W-1:0] wr_adr_q;
        word_t             wr_dat_q;
        logic [SEL_W-1:0]  wr_sel_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                wr_v_q   <= 1'b0;
                wr_adr_q <= '0;
                wr_dat_q <= '0;
                wr_sel_q <= '0;
            end else begin
                wr_v_q <= wr_req;
                if (wr_req) begin
                    wr_adr_q <= wb_adr_i;
                    wr_dat_q <= wb_dat_i;
                    wr_sel_q <= wb_sel_i;
                end
            end
        end

        assign wr_com_o = wr_v_q;
        assign wr_adr_o = wr_adr_q;
        assign wr_dat_o = wr_dat_q;
        assign wr_sel_o = wr_sel_q;
    end else begin : g_wr_comb
        assign wr_com_o = wr_req;
        assign wr_adr_o = wb_adr_i;
        assign wr_dat_o = wb_dat_i;
        assign wr_sel_o = wb_sel_i;
    end

    // RO sources are sampled in the decode cycle, so the stage captures data, not address.
    if (RD_PIPE != 0) begin : g_rd_pipe
        logic              ack_q;
        logic              err_q;
        word_t             dat_q;
        logic [ADDR_W-1:0] adr_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                ack_q <= 1'b0;
                err_q <= 1'b0;
                dat_q <= '0;
                adr_q <= '0;
            end else begin
                ack_q <= rd_req & rd_map_i;
                err_q <= rd_req & ~rd_map_i;
                dat_q <= rd_req ? rd_dat_i : '0;
                adr_q <= wb_adr_i;
            end
        end

        assign rd_ack       = ack_q;
        assign rd_err       = err_q;
        assign rd_dat       = dat_q;
        assign rd_ack_adr_o = adr_q;
    end else begin : g_rd_comb
        assign rd_ack       = rd_req & rd_map_i;
        assign rd_err       = rd_req & ~rd_map_i;
        assign rd_dat       = rd_req ? rd_dat_i : '0;
        assign rd_ack_adr_o = wb_adr_i;
    end

    assign wr_ack = wr_com_o & wr_map_i;
    assign wr_err = wr_com_o & ~wr_map_i;

    always_comb begin
        rip_d = (rip_q | rd_req) & ~(rd_ack | rd_err);
        wip_d = (wip_q | wr_req) & ~(wr_ack | wr_err);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rip_q <= 1'b0;
            wip_q <= 1'b0;
        end else begin
            rip_q <= rip_d;
            wip_q <= wip_d;
        end
    end

    assign rd_ack_o   = rd_ack;
    assign wb_ack_o   = rd_ack | wr_ack;
    assign wb_err_o   = rd_err | wr_err;
    assign wb_stall_o = en & ~(wb_ack_o | wb_err_o);
    assign wb_dat_o   = rd_dat;

endmodule

// File: rtl/wb_reg_bank.sv
// rtl/wb_reg_bank.sv - Wishbone register bank: RW/RO register array, decode, write strobes
// Optional: define WB_REG_BANK_RD_STROBE_EN to add per-register read strobes on reg_rd_o.
module wb_reg_bank
    import wb_reg_bank_pkg::*;
#(
    parameter int                  NREGS   = 4,
    parameter int                  ADDR_W  = 2,
    parameter logic [NREGS-1:0]    RW_MASK = '1,
    parameter logic [NREGS*32-1:0] RST_VAL = '0,
    parameter int                  WR_PIPE = 1,
    parameter int                  RD_PIPE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [ADDR_W-1:0]     wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_dat_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic                  wb_stall_o,
    output logic [31:0]           wb_dat_o,
    input  logic [NREGS*32-1:0]   reg_i,
    output logic [NREGS*32-1:0]   reg_o,
    output logic [NREGS-1:0]      reg_wr_o
`ifdef WB_REG_BANK_RD_STROBE_EN
    ,
    output logic [NREGS-1:0]      reg_rd_o
`endif
);

    logic [ADDR_W-1:0]       rd_adr;
    logic [ADDR_W-1:0]       rd_ack_adr;
    logic [ADDR_W-1:0]       wr_adr;
    logic                    rd_map;
    logic                    wr_map;
    logic                    rd_ack;
    logic                    wr_com;
    word_t                   rd_dat;
    word_t                   wr_dat;
    logic [SEL_W-1:0]        wr_sel;
    logic [NREGS*DATA_W-1:0] cur_flat;
    logic [NREGS-1:0]        reg_wr;

    assign wb_rty_o = 1'b0;

    wb_reg_bank_if #(
        .ADDR_W  (ADDR_W),
        .WR_PIPE (WR_PIPE),
        .RD_PIPE (RD_PIPE)
    ) u_if (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_stb_i     (wb_stb_i),
        .wb_adr_i     (wb_adr_i),
        .wb_sel_i     (wb_sel_i),
        .wb_we_i      (wb_we_i),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_o     (wb_ack_o),
        .wb_err_o     (wb_err_o),
        .wb_stall_o   (wb_stall_o),
        .wb_dat_o     (wb_dat_o),
        .rd_adr_o     (rd_adr),
        .rd_map_i     (rd_map),
        .rd_dat_i     (rd_dat),
        .rd_ack_o     (rd_ack),
        .rd_ack_adr_o (rd_ack_adr),
        .wr_com_o     (wr_com),
        .wr_adr_o     (wr_adr),
        .wr_dat_o     (wr_dat),
        .wr_sel_o     (wr_sel),
        .wr_map_i     (wr_map)
    );

    assign rd_map = 32'(rd_adr) < NREGS;
    assign wr_map = 32'(wr_adr) < NREGS;

    // Unmapped addresses match no index and therefore read as zero.
    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_adr == ADDR_W'(i)) begin
                rd_dat = cur_flat[DATA_W*i +: DATA_W];
            end
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (RW_MASK[i]) begin : g_rw
            word_t val_q;
            logic  unused_src;

            assign reg_wr[i] = wr_com & (wr_adr == ADDR_W'(i));

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    val_q <= RST_VAL[DATA_W*i +: DATA_W];
                end else if (reg_wr[i]) begin
                    val_q <= byte_merge(val_q, wr_dat, wr_sel);
                end
            end

            assign cur_flat[DATA_W*i +: DATA_W] = val_q;
            assign reg_o[DATA_W*i +: DATA_W]    = val_q;
            assign unused_src                   = ^reg_i[DATA_W*i +: DATA_W];
        end else begin : g_ro
            assign reg_wr[i]                    = 1'b0;
            assign cur_flat[DATA_W*i +: DATA_W] = reg_i[DATA_W*i +: DATA_W];
            assign reg_o[DATA_W*i +: DATA_W]    = '0;
        end
    end

    assign reg_wr_o = reg_wr;

`ifdef WB_REG_BANK_RD_STROBE_EN
    for (genvar i = 0; i < NREGS; i++) begin : g_rd_stb
        assign reg_rd_o[i] = rd_ack & (rd_ack_adr == ADDR_W'(i));
    end
`else
    logic unused_rd;
    assign unused_rd = rd_ack ^ (^rd_ack_adr);
`endif

endmodule

// File: tb/tb_wb_reg_bank.sv
// tb/tb_wb_reg_bank.sv - randomized model-checked bench over all four WR_PIPE/RD_PIPE builds
module tb_wb_reg_bank;

    localparam logic [127:0] RST = {32'h0, 32'h0000_0200, 32'h0, 32'h0};
    localparam logic [3:0]   RW  = 4'b0111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cyc    [4];
    logic         stb    [4];
    logic         we     [4];
    logic [2:0]   adr    [4];
    logic [3:0]   sel    [4];
    logic [31:0]  dat_i  [4];
    logic         ack    [4];
    logic         err    [4];
    logic         rty    [4];
    logic         stall  [4];
    logic [31:0]  dat_o  [4];
    logic [127:0] reg_i  [4];
    logic [127:0] reg_o  [4];
    logic [3:0]   reg_wr [4];
`ifdef WB_REG_BANK_RD_STROBE_EN
    logic [3:0]   reg_rd [4];
`endif

    int total = 0;
    int bad   = 0;
    int cur_k = 0;
    logic [31:0] mdl [4][4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wb_reg_bank #(
            .NREGS   (4),
            .ADDR_W  (3),
            .RW_MASK (4'b0111),
            .RST_VAL (RST),
            .WR_PIPE (g / 2),
            .RD_PIPE (g % 2)
        ) u_dut (
            .clk_i      (clk),
            .rst_n_i    (rst_n),
            .wb_cyc_i   (cyc[g]),
            .wb_stb_i   (stb[g]),
            .wb_adr_i   (adr[g]),
            .wb_sel_i   (sel[g]),
            .wb_we_i    (we[g]),
            .wb_dat_i   (dat_i[g]),
            .wb_ack_o   (ack[g]),
            .wb_err_o   (err[g]),
            .wb_rty_o   (rty[g]),
            .wb_stall_o (stall[g]),
            .wb_dat_o   (dat_o[g]),
            .reg_i      (reg_i[g]),
            .reg_o      (reg_o[g]),
            .reg_wr_o   (reg_wr[g])
`ifdef WB_REG_BANK_RD_STROBE_EN
            ,
            .reg_rd_o   (reg_rd[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL dut%0d %s got=%h exp=%h", cur_k, tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_reg_o(input int k);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (RW[i]) v[32*i +: 32] = mdl[k][i];
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) mdl[k][i] = RST[32*i +: 32];
        end
    endtask

    // Presents one request right after a rising edge and returns just after the edge ending the response cycle.
    task automatic txn(input int k, input logic w, input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
        int          lat;
        int          exp_lat;
        logic        mapped;
        logic [31:0] exp_dat;
        logic [3:0]  exp_wr;
        logic [3:0]  exp_rd;
        logic [31:0] m;
        cur_k   = k;
        mapped  = (a < 3'd4);
        exp_lat = w ? (k / 2) : (k % 2);
        exp_dat = '0;
        exp_wr  = '0;
        exp_rd  = '0;
        if (mapped) begin
            if (w && RW[a[1:0]]) exp_wr[a[1:0]] = 1'b1;
            if (!w) begin
                exp_rd[a[1:0]] = 1'b1;
                exp_dat = RW[a[1:0]] ? mdl[k][a[1:0]] : reg_i[k][32*a[1:0] +: 32];
            end
        end
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat_i[k] = d;
        @(negedge clk);
        check("reg_o", reg_o[k], exp_reg_o(k));
        lat = 0;
        while (!(ack[k] || err[k]) && lat < 3) begin
            check("stall_wait", stall[k], 1);
            check("wr_stb_idle", reg_wr[k], 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("ack", ack[k], mapped);
        check("err", err[k], !mapped);
        check("stall_resp", stall[k], 0);
        check("rty", rty[k], 0);
        check("wr_stb", reg_wr[k], exp_wr);
        if (!w) check("rd_dat", dat_o[k], exp_dat);
`ifdef WB_REG_BANK_RD_STROBE_EN
        check("rd_stb", reg_rd[k], exp_rd);
`endif
        if (w && mapped && RW[a[1:0]]) begin
            m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            mdl[k][a[1:0]] = (mdl[k][a[1:0]] & ~m) | (d & m);
        end
        @(posedge clk);
        #1;
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            adr[k] = '0; sel[k] = '0; dat_i[k] = '0;
            reg_i[k] = {$urandom, $urandom, $urandom, $urandom};
        end
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            cur_k = k;
            check("rst_ack", ack[k], 0);
            check("rst_err", err[k], 0);
            check("rst_stall", stall[k], 0);
            check("rst_wr_stb", reg_wr[k], 0);
            check("rst_dat", dat_o[k], 0);
            check("rst_reg_o", reg_o[k], exp_reg_o(k));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            reg_i[k][127:96] = 32'h1234_5678;
            txn(k, 1'b0, 3'd2, 4'hf, 32'h0);
            txn(k, 1'b1, 3'd1, 4'b0101, 32'hDEAD_BEEF);
            @(negedge clk);
            check("merge_const", reg_o[k][63:32], 32'h00AD_00EF);
            @(posedge clk);
            #1;
            txn(k, 1'b0, 3'd1, 4'hf, 32'h0);
            txn(k, 1'b0, 3'd3, 4'hf, 32'h0);
            txn(k, 1'b1, 3'd3, 4'hf, 32'hFFFF_0000);
            txn(k, 1'b0, 3'd3, 4'hf, 32'h0);
            txn(k, 1'b0, 3'd5, 4'hf, 32'h0);
            txn(k, 1'b1, 3'd5, 4'hf, 32'h5555_AAAA);
            txn(k, 1'b1, 3'd0, 4'hf, 32'hA5A5_0F0F);
            txn(k, 1'b0, 3'd0, 4'hf, 32'h0);
            txn(k, 1'b1, 3'd0, 4'h0, 32'h1111_2222);
            txn(k, 1'b0, 3'd0, 4'hf, 32'h0);
            for (int n = 0; n < 30; n++) begin
                reg_i[k] = {$urandom, $urandom, $urandom, $urandom};
                txn(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom), $urandom);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            @(negedge clk);
            check("wr_stb_after", reg_wr[k], 0);
            check("reg_o_after", reg_o[k], exp_reg_o(k));
            @(posedge clk);
            #1;
        end

        cur_k = 3;
        cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; adr[3] = 3'd1; sel[3] = 4'hf; dat_i[3] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_ack", ack[3], 0);
        check("midrst_err", err[3], 0);
        check("midrst_wr_stb", reg_wr[3], 0);
        check("midrst_dat", dat_o[3], 0);
        check("midrst_reg_o", reg_o[3], exp_reg_o(3));
        cyc[3] = 1'b0; stb[3] = 1'b0; we[3] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_reg_o", reg_o[3], exp_reg_o(3));
        check("postrst_ack", ack[3], 0);
        @(posedge clk);
        #1;
        txn(3, 1'b0, 3'd1, 4'hf, 32'h0);
        txn(3, 1'b0, 3'd2, 4'hf, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
